// File: rtl/stream_zero_padding.sv
// stream_zero_padding: streams an R_N x C_N multi-channel feature map (valid/ready,
// row-major) out as an (R_N+2P) x (C_N+2P) map with PAD_VAL beats on every border.
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle frame start pulse, ignored while busy
//   in_data/in_valid    upstream pixel stream; in_ready is driven only on interior beats
//   out_data/out_valid  padded pixel stream; out_ready is the downstream backpressure
//   out_eol, out_last   last beat of the padded row / of the frame
//   busy, done          frame in progress / one-cycle pulse after the final beat
module stream_zero_padding #(
    parameter int                 In_d_W  = 32,
    parameter int                 CH      = 1,
    parameter int                 R_N     = 3,
    parameter int                 C_N     = 3,
    parameter int                 P       = 1,
    parameter logic [In_d_W-1:0]  PAD_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CH*In_d_W-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [CH*In_d_W-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_eol,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);
    localparam int RT = R_N + 2 * P;
    localparam int CT = C_N + 2 * P;
    localparam int RW = RT > 1 ? $clog2(RT) : 1;
    localparam int CW = CT > 1 ? $clog2(CT) : 1;
    localparam logic [RW-1:0] R_MAX = RW'(RT - 1);
    localparam logic [CW-1:0] C_MAX = CW'(CT - 1);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          run, pad, hs, at_eol, at_last;
    // Pad/data is decided purely from the current output coordinate; interior beats
    // are a zero-latency combinational bypass of the input stream.
    always_comb begin
        run       = state == RUN;
        pad       = int'(row) < P || int'(row) >= R_N + P || int'(col) < P || int'(col) >= C_N + P;
        out_valid = run && (pad || in_valid);
        in_ready  = run && !pad && out_ready;
        out_data  = !run ? '0 : pad ? {CH{PAD_VAL}} : in_data;
        at_eol    = col == C_MAX;
        at_last   = at_eol && row == R_MAX;
        out_eol   = out_valid && at_eol;
        out_last  = out_valid && at_last;
        hs        = out_valid && out_ready;
        busy      = state != IDLE;
        done      = state == FIN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= RUN;
                RUN: if (hs) begin
                    if (at_last) begin
                        state <= FIN;
                        row   <= '0;
                        col   <= '0;
                    end else if (at_eol) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
